// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: round-robin sharing of one LSB-first SPI master among NUM_REQ requesters.
// Define SPI_ARB_TIMEOUT_EN to abort frames that run longer than TIMEOUT cycles.
module spi_req_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 12,
   parameter int TIMEOUT = 1023
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        ack,
   output logic [NUM_REQ-1:0]        gnt,
   output logic                      busy,
   output logic                      spi_newd,
   output logic [DATA_W-1:0]         spi_din,
   input  logic                      spi_cs,
   output logic                      err
);
   localparam int IW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, LAUNCH, ACTIVE, DONE} state_t;

   state_t              state_q;
   logic [IW-1:0]       ptr_q;
   logic [IW-1:0]       idx_q;
   logic [IW-1:0]       win_d;
   logic [IW-1:0]       cand;
   logic [NUM_REQ-1:0]  gnt_q;
   logic [NUM_REQ-1:0]  ack_q;
   logic [DATA_W-1:0]   word_q;
   logic                newd_q;
   logic                cs_m_q;
   logic                cs_s_q;
   logic                tmo;

   // Walk downward so the candidate closest after ptr_q is written last and wins.
   always_comb begin
      win_d = ptr_q;
      cand  = ptr_q;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = IW'((int'(ptr_q) + k) % NUM_REQ);
         if (req[cand])
            win_d = cand;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= IW'(NUM_REQ - 1);
         idx_q   <= '0;
         gnt_q   <= '0;
         ack_q   <= '0;
         word_q  <= '0;
         newd_q  <= 1'b0;
         cs_m_q  <= 1'b1;
         cs_s_q  <= 1'b1;
      end else begin
         cs_m_q <= spi_cs;
         cs_s_q <= cs_m_q;
         ack_q  <= '0;
         if (tmo) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            newd_q  <= 1'b0;
            ptr_q   <= idx_q;
         end else begin
            case (state_q)
               IDLE: begin
                  if (|req) begin
                     state_q <= LAUNCH;
                     idx_q   <= win_d;
                     gnt_q   <= NUM_REQ'(1) << win_d;
                     word_q  <= req_data[win_d*DATA_W +: DATA_W];
                     newd_q  <= 1'b1;
                  end
               end
               LAUNCH: begin
                  if (!cs_s_q) begin
                     state_q <= ACTIVE;
                     newd_q  <= 1'b0;
                  end
               end
               ACTIVE: begin
                  if (cs_s_q) begin
                     state_q <= DONE;
                     ack_q   <= gnt_q;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  gnt_q   <= '0;
                  ptr_q   <= idx_q;
               end
            endcase
         end
      end
   end

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] timer_q;
   logic          err_q;

   // Timer sits at zero in IDLE, so it restarts from zero at every grant.
   assign tmo = (state_q == LAUNCH || state_q == ACTIVE) && timer_q == TW'(TIMEOUT - 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         timer_q <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q   <= tmo;
         timer_q <= (state_q == IDLE) ? '0 : timer_q + 1'b1;
      end
   end

   assign err = err_q;
`else
   assign tmo = 1'b0;
   assign err = 1'b0;
`endif

   assign gnt      = gnt_q;
   assign ack      = ack_q;
   assign busy     = state_q != IDLE;
   assign spi_newd = newd_q;
   assign spi_din  = word_q;

endmodule

// File: doc/spi_req_arbiter.md
Name: spi_req_arbiter

Overview:
Shares one 12-bit LSB-first SPI master (newd/din in, cs out) between NUM_REQ on-chip requesters.
- Round-robin arbitration over the request lines.
- Latches the winner's word and drives the master's launch handshake.
- Tracks frame start and end through the master's chip-select.
- Returns a per-requester completion pulse.
- Sits between client logic and the SPI master, in the clk domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 12, SPI frame width; must match the master
TIMEOUT, 1023, clk cycles allowed from launch to frame end (used only with SPI_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req  in  NUM_REQ  level request per requester; held until its ack
req_data  in  NUM_REQ*DATA_W  word per requester; slice i = bits [i*DATA_W +: DATA_W]
ack  out  NUM_REQ  one-cycle completion pulse to the granted requester
gnt  out  NUM_REQ  one-hot; high from grant to ack inclusive
busy  out  1  high in any state other than IDLE
spi_newd  out  1  launch request to the SPI master
spi_din  out  DATA_W  word to the SPI master
spi_cs  in  1  master chip-select, active low
err  out  1  one-cycle timeout pulse (SPI_ARB_TIMEOUT_EN only; else tied 0)

Behaviour:
- Reset values:
  - Outputs: ack=0, gnt=0, busy=0, spi_newd=0, spi_din=0, err=0.
  - State: state=IDLE, rr pointer=NUM_REQ-1.
  - Internal regs: both cs synchronizer flops=1, latched word=0, timer=0.
- spi_cs passes through a 2-flop synchronizer; all decisions use cs_s (the synchronized value).
- IDLE:
  - If req != 0, pick the first set bit searching from ptr+1 upward, with wrap-around.
  - Register gnt (one-hot) and the latched word = the winner's slice.
  - Go to LAUNCH. Grant happens 1 cycle after req is seen.
- LAUNCH:
  - Drive spi_newd=1 and spi_din=latched word.
  - Stay until cs_s==0, then go to ACTIVE with spi_newd=0 in the same cycle.
  - spi_din holds the latched word until the next grant.
- ACTIVE: wait for cs_s==1, then go to DONE.
- DONE:
  - ack = gnt for exactly 1 cycle; ptr = granted index.
  - Next cycle: gnt=0, go to IDLE.
  - The next arbitration happens no earlier than the cycle after DONE.
- Requests:
  - Dropping req while granted has no effect; the frame completes and ack still pulses.
  - req_data is sampled only at grant; later changes are ignored.
  - New requests are never dropped, only deferred.
- Fairness:
  - The last-served requester has the lowest priority in the next arbitration.
  - With all req high, grants rotate 0,1,2,3,0...
  - With a single requester, it is re-granted on every IDLE visit.
- Reset mid-operation: immediate return to reset values. The master is reset on the same rst, so no frame is completed.
- gnt is always one-hot or zero; ack is a subset of gnt.

Optional Feature:
SPI_ARB_TIMEOUT_EN:
- Defined:
  - A timer clears on grant and increments each cycle in LAUNCH or ACTIVE.
  - When it reaches TIMEOUT: err=1 for 1 cycle, spi_newd=0, no ack, gnt=0.
  - The state returns to IDLE and ptr advances to the granted index, so the stuck requester loses priority.
- Undefined: no timer; err is constant 0; LAUNCH and ACTIVE wait indefinitely.

Test Plan:
- After reset with req=0: 20 cycles -> busy=0, gnt=0, spi_newd=0, ack=0.
- req=4'b0001 with slice0=12'hA5C; bench models cs falling 30 cycles after newd and rising 300 cycles later -> gnt=0001 one cycle after req; spi_din=A5C; newd drops 2-3 cycles after cs falls; one ack[0] pulse 2-3 cycles after cs rises.
- req=4'b1111 held, each requester re-raising after ack -> grant order 0,1,2,3,0; no two acks in the same cycle; no gnt overlap.
- req[2] asserted during requester 1's frame, after rst -> requester 2 is served next; its data is sampled at its own grant, not earlier.
- rst pulsed for 1 cycle while in ACTIVE -> next cycle all outputs are 0, state is IDLE, and no ack is issued for the aborted frame.
- With SPI_ARB_TIMEOUT_EN and TIMEOUT=50, cs held high -> err pulses exactly 50 cycles after grant, no ack; requester 1 is granted next when req=4'b0011 after requester 0 times out.
